// File: rtl/pipe_pkg.sv
// Shared decode constants and the skid-buffer state type for the IF/ID boundary.
package pipe_pkg;

    localparam int OPCODE_W = 6;

    localparam logic [OPCODE_W-1:0] OP_ANDI = 6'h0C;
    localparam logic [OPCODE_W-1:0] OP_ORI  = 6'h0D;
    localparam logic [OPCODE_W-1:0] OP_XORI = 6'h0E;
    localparam logic [OPCODE_W-1:0] OP_LUI  = 6'h0F;

    // Extender select encoding shared with the ID-stage immediate extender
    localparam logic EXT_ZERO = 1'b0;
    localparam logic EXT_SIGN = 1'b1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_e;

endpackage

// File: rtl/if_id_skid_buffer_if.sv
// Fetch-to-decode handshake bundle; slave is the buffer's view, master the surrounding pipeline's.
interface if_id_skid_buffer_if #(
    parameter int INSTR_W = 32,
    parameter int IMM_W   = 16
);
    logic               if_valid;
    logic               if_ready;
    logic [INSTR_W-1:0] if_pc;
    logic [INSTR_W-1:0] if_instr;
    logic               id_valid;
    logic               id_ready;
    logic [INSTR_W-1:0] id_pc;
    logic [INSTR_W-1:0] id_instr;
    logic [IMM_W-1:0]   id_imm16;
    logic               id_ext_op;

    modport slave (
        input  if_valid, if_pc, if_instr, id_ready,
        output if_ready, id_valid, id_pc, id_instr, id_imm16, id_ext_op
    );

    modport master (
        output if_valid, if_pc, if_instr, id_ready,
        input  if_ready, id_valid, id_pc, id_instr, id_imm16, id_ext_op
    );
endinterface

// File: rtl/ext_op_decode.sv
// Opcode to extender select: logical immediates and LUI zero-extend, everything else sign-extends.
module ext_op_decode
    import pipe_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode_i,
    output logic                ext_op_o
);

    always_comb begin
        ext_op_o = EXT_SIGN;
        case (opcode_i)
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: ext_op_o = EXT_ZERO;
            default: ;
        endcase
    end

endmodule

// File: rtl/if_id_skid_buffer.sv
// Two-entry IF/ID skid buffer with registered if_ready, flush and a saturating stall counter.
//   state | meaning
//   EMPTY | no beat held, id_valid=0
//   ONE   | main register holds the head beat
//   TWO   | main and skid both hold beats, fetch is back-pressured
module if_id_skid_buffer
    import pipe_pkg::*;
#(
    parameter int INSTR_W = 32,
    parameter int IMM_W   = 16,
    parameter int CNT_W   = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    if_id_skid_buffer_if.slave  bus,
    output logic [CNT_W-1:0]    stall_cnt_o
);

    skid_state_e        state_q, state_d;
    logic [INSTR_W-1:0] main_pc_q, main_instr_q;
    logic [INSTR_W-1:0] skid_pc_q, skid_instr_q;
    logic               main_ext_q, skid_ext_q;
    logic               if_ready_q;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic               in_ext;
    logic               id_valid, push, pop;
    logic               load_main_in, load_main_skid, load_skid;

    // ext_op is resolved once at push so decode never looks at the opcode
    ext_op_decode u_ext_op_decode (
        .opcode_i (bus.if_instr[INSTR_W-1 -: OPCODE_W]),
        .ext_op_o (in_ext)
    );

    assign id_valid = (state_q != EMPTY);
    assign push     = bus.if_valid & if_ready_q;
    assign pop      = id_valid & bus.id_ready;

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d      = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (push && pop) begin
                    load_main_in = 1'b1;
                end else if (push) begin
                    state_d   = TWO;
                    load_skid = 1'b1;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    state_d        = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        // A flushed push is dropped; leaving data untouched keeps id_* stable
        if (flush_i) begin
            state_d        = EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (id_valid && !bus.id_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= EMPTY;
            if_ready_q   <= 1'b0;
            stall_cnt_q  <= '0;
            main_pc_q    <= '0;
            main_instr_q <= '0;
            main_ext_q   <= EXT_ZERO;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
            skid_ext_q   <= EXT_ZERO;
        end else begin
            state_q     <= state_d;
            if_ready_q  <= (state_d != TWO);
            stall_cnt_q <= stall_cnt_d;
            if (load_main_in) begin
                main_pc_q    <= bus.if_pc;
                main_instr_q <= bus.if_instr;
                main_ext_q   <= in_ext;
            end else if (load_main_skid) begin
                main_pc_q    <= skid_pc_q;
                main_instr_q <= skid_instr_q;
                main_ext_q   <= skid_ext_q;
            end
            if (load_skid) begin
                skid_pc_q    <= bus.if_pc;
                skid_instr_q <= bus.if_instr;
                skid_ext_q   <= in_ext;
            end
        end
    end

    assign bus.if_ready  = if_ready_q;
    assign bus.id_valid  = id_valid;
    assign bus.id_pc     = main_pc_q;
    assign bus.id_instr  = main_instr_q;
    assign bus.id_imm16  = main_instr_q[IMM_W-1:0];
    assign bus.id_ext_op = main_ext_q;
    assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_if_id_skid_buffer.sv
// Scoreboard bench: a two-deep FIFO model predicts handshakes, beats, ext_op and the stall counter.
module tb_if_id_skid_buffer;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [15:0] imm;
        logic        ext;
    } beat_t;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic [CNT_W-1:0] stall_cnt;

    if_id_skid_buffer_if #(.INSTR_W(32), .IMM_W(16)) bus ();

    if_id_skid_buffer #(.INSTR_W(32), .IMM_W(16), .CNT_W(CNT_W)) u_dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .flush_i     (flush),
        .bus         (bus),
        .stall_cnt_o (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    beat_t mq[$];
    bit    m_ready = 0;
    int    m_stall = 0;
    bit    m_zero  = 0;
    bit    m_init  = 0;
    bit    last_push = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic beat_t mk_beat(input logic [31:0] pc, input logic [31:0] instr);
        beat_t b;
        int    op;
        op      = int'(instr[31:26]);
        b.pc    = pc;
        b.instr = instr;
        b.imm   = instr[15:0];
        b.ext   = !(op >= 12 && op <= 15);
        return b;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 1) == 1) r[31:26] = 6'($urandom_range(12, 15));
        else                           r[31:26] = 6'($urandom_range(0, 63));
        return r;
    endfunction

    // Monitor: compare outputs against the model, then advance the model for the coming edge
    always @(negedge clk) begin
        bit do_push, do_pop;
        if (m_init) begin
            chk("if_ready", 64'(bus.if_ready), 64'(m_ready));
            chk("id_valid", 64'(bus.id_valid), 64'(mq.size() > 0));
            chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
            if (m_zero) begin
                chk("rst_id_pc", 64'(bus.id_pc), 64'(0));
                chk("rst_id_instr", 64'(bus.id_instr), 64'(0));
                chk("rst_id_imm16", 64'(bus.id_imm16), 64'(0));
                chk("rst_id_ext_op", 64'(bus.id_ext_op), 64'(0));
            end
            if (rst_n && bus.id_valid && bus.id_ready) begin
                if (mq.size() == 0) begin
                    chk("unexpected_beat", 64'(bus.id_pc), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    chk("beat_pc", 64'(bus.id_pc), 64'(mq[0].pc));
                    chk("beat_instr", 64'(bus.id_instr), 64'(mq[0].instr));
                    chk("beat_imm16", 64'(bus.id_imm16), 64'(mq[0].imm));
                    chk("beat_ext_op", 64'(bus.id_ext_op), 64'(mq[0].ext));
                end
            end
        end
        last_push = 0;
        if (!rst_n) begin
            mq.delete();
            m_ready = 0;
            m_stall = 0;
            m_zero  = 1;
            m_init  = 1;
        end else if (m_init) begin
            m_zero  = 0;
            do_push = bus.if_valid && m_ready;
            do_pop  = (mq.size() > 0) && bus.id_ready;
            if ((mq.size() > 0) && !bus.id_ready && m_stall < CNT_MAX) m_stall++;
            if (do_pop) void'(mq.pop_front());
            if (flush)        mq.delete();
            else if (do_push) mq.push_back(mk_beat(bus.if_pc, bus.if_instr));
            m_ready   = (mq.size() < 2);
            last_push = do_push && !flush;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until the model sees it accepted
    task automatic send(input logic [31:0] pc, input logic [31:0] instr);
        int n;
        bus.if_valid = 1'b1;
        bus.if_pc    = pc;
        bus.if_instr = instr;
        n = 0;
        do begin
            tick();
            n++;
        end while (!last_push && n < 100);
        if (!last_push) begin
            checks++;
            errors++;
            $display("FAIL send_timeout pc=%0h waited=%0d cycles", pc, n);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        flush        = 1'b0;
        bus.if_valid = 1'b0;
        bus.if_pc    = '0;
        bus.if_instr = '0;
        bus.id_ready = 1'b0;

        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        bus.id_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(32'(i * 4), 32'h2008FFFF);
        bus.if_valid = 1'b0;
        repeat (3) tick();

        bus.id_ready = 1'b0;
        send(32'h10, 32'h3508FFFF);
        send(32'h14, 32'h8D090004);
        bus.if_valid = 1'b1;
        bus.if_pc    = 32'h18;
        bus.if_instr = 32'h20090001;
        repeat (3) tick();
        bus.id_ready = 1'b1;
        send(32'h18, 32'h20090001);
        bus.if_valid = 1'b0;
        repeat (4) tick();

        bus.id_ready = 1'b0;
        send(32'h20, 32'h31080F0F);
        send(32'h24, 32'hAD0A0008);
        bus.if_valid = 1'b1;
        bus.if_pc    = 32'h28;
        bus.if_instr = 32'h3C0A1234;
        flush        = 1'b1;
        tick();
        flush        = 1'b0;
        bus.if_valid = 1'b0;
        bus.id_ready = 1'b1;
        repeat (4) tick();

        bus.id_ready = 1'b0;
        send(32'h30, 32'h2108FFFE);
        bus.if_valid = 1'b0;
        repeat (20) tick();
        @(negedge clk);
        chk("stall_saturated", 64'(stall_cnt), 64'(CNT_MAX));
        tick();
        bus.id_ready = 1'b1;
        repeat (3) tick();

        bus.id_ready = 1'b0;
        send(32'h40, 32'h38081111);
        send(32'h44, 32'h8D0B0010);
        bus.if_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (4) tick();

        for (int c = 0; c < 1500; c++) begin
            if (!bus.if_valid || last_push) begin
                bus.if_valid = ($urandom_range(0, 3) != 0);
                bus.if_pc    = $urandom;
                bus.if_instr = rand_instr();
            end
            bus.id_ready = ($urandom_range(0, 2) != 0);
            flush        = ($urandom_range(0, 19) == 0);
            tick();
        end

        bus.if_valid = 1'b0;
        bus.id_ready = 1'b1;
        flush        = 1'b0;
        repeat (5) tick();
        @(negedge clk);
        #1;
        chk("drained", 64'(mq.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
